// File: rtl/cb_policy_ctrl_if.sv
// Bundle of inference inputs, engine circuit-breaker command/status and policy observability.
// Latency: none, wiring only.
// Backpressure: none; the ML strobe and engine load pulse are single-cycle, no ready path.
interface cb_policy_ctrl_if;
  logic       ml_valid;
  logic [2:0] ml_class;
  logic [7:0] ml_conf;
  logic       cb_active_in;
  logic       host_clear;
  logic [1:0] cb_mode;
  logic [7:0] cb_param;
  logic       cb_load;
  logic [1:0] policy_state;
  logic [7:0] trip_count;
  logic [7:0] suppressed_count;

  // Inference source, host and engine side.
  modport master (
    output ml_valid, ml_class, ml_conf, cb_active_in, host_clear,
    input  cb_mode, cb_param, cb_load, policy_state, trip_count, suppressed_count
  );

  // Policy controller side.
  modport slave (
    input  ml_valid, ml_class, ml_conf, cb_active_in, host_clear,
    output cb_mode, cb_param, cb_load, policy_state, trip_count, suppressed_count
  );
endinterface

// File: rtl/cb_policy_ctrl.sv
// Turns ML anomaly inferences into circuit-breaker loads (confidence filter, persistence, escalation-only, cooldown).
// Latency: cb_load and its mode/param appear one cycle after the triggering input; all outputs registered.
// Backpressure: none; inferences not acted on are dropped. CB_POLICY_STATS_EN builds the suppressed counter.
module cb_policy_ctrl #(
  parameter int unsigned CONF_MIN   = 128,
  parameter int unsigned FAST_CONF  = 224,
  parameter int unsigned PERSIST    = 3,
  parameter int unsigned ARM_WINDOW = 64,
  parameter int unsigned COOLDOWN   = 256
) (
  input logic            clk,
  input logic            rst_n,
  cb_policy_ctrl_if.slave pif
);

  localparam logic [7:0] CONF_MIN_C   = 8'(CONF_MIN);
  localparam logic [7:0] FAST_CONF_C  = 8'(FAST_CONF);
  localparam logic [3:0] PERSIST_C    = 4'(PERSIST);
  localparam logic [9:0] ARM_WINDOW_C = 10'(ARM_WINDOW);
  localparam logic [9:0] COOLDOWN_C   = 10'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ENGAGED  = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] arm_q, arm_d;
  logic [9:0] cd_q, cd_d;
  logic [1:0] guard_q, guard_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] param_q, param_d;
  logic       load_q, load_d;
  logic [7:0] trip_q, trip_d;

  logic       do_load;
  logic [1:0] ld_mode;
  logic [7:0] ld_param;
  logic       qual, fast;
  logic [1:0] in_mode;

  // Classes 1..3 map straight onto modes 01..11; 0 and 4..7 never qualify.
  assign in_mode = pif.ml_class[1:0];
  assign qual    = pif.ml_valid && (pif.ml_class inside {3'd1, 3'd2, 3'd3}) &&
                   (pif.ml_conf >= CONF_MIN_C);
  assign fast    = qual && (pif.ml_class == 3'd3) && (pif.ml_conf >= FAST_CONF_C);

  // Next-state and load decision; host_clear overrides everything, load side effects applied last.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    cd_d     = cd_q;
    guard_d  = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    mode_d   = mode_q;
    param_d  = param_q;
    load_d   = 1'b0;
    trip_d   = trip_q;
    do_load  = 1'b0;
    ld_mode  = 2'b00;
    ld_param = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (fast) begin
          do_load = 1'b1; ld_mode = 2'b11; ld_param = pif.ml_conf;
          state_d = ST_ENGAGED;
        end else if (qual) begin
          cand_d = in_mode;
          cnt_d  = 4'd1;
          if (PERSIST_C == 4'd1) begin
            do_load = 1'b1; ld_mode = in_mode; ld_param = pif.ml_conf;
            state_d = ST_ENGAGED;
          end else begin
            state_d = ST_ARMING;
            arm_d   = 10'd0;
          end
        end
      end
      ST_ARMING: begin
        if (pif.ml_valid) begin
          arm_d = 10'd0;
          if (fast) begin
            do_load = 1'b1; ld_mode = 2'b11; ld_param = pif.ml_conf;
            state_d = ST_ENGAGED;
            cnt_d   = 4'd0;
          end else if (qual && (in_mode == cand_q)) begin
            if (cnt_q + 4'd1 >= PERSIST_C) begin
              do_load = 1'b1; ld_mode = in_mode; ld_param = pif.ml_conf;
              state_d = ST_ENGAGED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (qual) begin
            cand_d = in_mode;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          arm_d = arm_q + 10'd1;
          if (arm_q + 10'd1 >= ARM_WINDOW_C) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_ENGAGED: begin
        // Escalation takes priority over a simultaneous engine self-heal.
        if (qual && (in_mode > mode_q)) begin
          do_load = 1'b1; ld_mode = in_mode; ld_param = pif.ml_conf;
        end else if ((guard_q == 2'd0) && !pif.cb_active_in) begin
          state_d = ST_COOLDOWN;
          cd_d    = COOLDOWN_C;
        end
      end
      default: begin
        if (fast) begin
          do_load = 1'b1; ld_mode = 2'b11; ld_param = pif.ml_conf;
          state_d = ST_ENGAGED;
          cd_d    = 10'd0;
        end else begin
          cd_d = (cd_q != 10'd0) ? cd_q - 10'd1 : 10'd0;
          if (cd_q <= 10'd1) state_d = ST_IDLE;
        end
      end
    endcase

    if (pif.host_clear) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      arm_d    = 10'd0;
      cd_d     = 10'd0;
      guard_d  = 2'd0;
      do_load  = 1'b1;
      ld_mode  = 2'b00;
      ld_param = 8'h00;
    end

    if (do_load) begin
      load_d  = 1'b1;
      mode_d  = ld_mode;
      param_d = ld_param;
      if (ld_mode != 2'b00) begin
        guard_d = 2'd2;
        if (trip_q != 8'hFF) trip_d = trip_q + 8'd1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= 2'd0;
      cnt_q   <= 4'd0;
      arm_q   <= 10'd0;
      cd_q    <= 10'd0;
      guard_q <= 2'd0;
      mode_q  <= 2'b00;
      param_q <= 8'h00;
      load_q  <= 1'b0;
      trip_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      cd_q    <= cd_d;
      guard_q <= guard_d;
      mode_q  <= mode_d;
      param_q <= param_d;
      load_q  <= load_d;
      trip_q  <= trip_d;
    end
  end

  assign pif.cb_mode      = mode_q;
  assign pif.cb_param     = param_q;
  assign pif.cb_load      = load_q;
  assign pif.policy_state = state_q;
  assign pif.trip_count   = trip_q;

`ifdef CB_POLICY_STATS_EN
  logic       supp_ev;
  logic [7:0] supp_q;

  // Qualifying inference that is neither an escalation in ENGAGED nor a fast re-engage in COOLDOWN.
  assign supp_ev = qual && !pif.host_clear &&
                   (((state_q == ST_ENGAGED) && (in_mode <= mode_q)) ||
                    ((state_q == ST_COOLDOWN) && !fast));

  // Saturating suppressed-inference counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) supp_q <= 8'h00;
    else if (supp_ev && (supp_q != 8'hFF)) supp_q <= supp_q + 8'd1;
  end

  assign pif.suppressed_count = supp_q;
`else
  assign pif.suppressed_count = 8'h00;
`endif

endmodule

// File: tb/tb_cb_policy_ctrl.sv
// Directed bench for cb_policy_ctrl at default parameters.
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the edge that consumed them.
// No backpressure to model; every step is a fixed number of cycles.
module tb_cb_policy_ctrl;

`ifdef CB_POLICY_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cb_policy_ctrl_if pif ();

  cb_policy_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic infer(input logic [2:0] cls, input logic [7:0] conf);
    pif.ml_valid = 1'b1;
    pif.ml_class = cls;
    pif.ml_conf  = conf;
    tick();
    pif.ml_valid = 1'b0;
    pif.ml_class = 3'd0;
    pif.ml_conf  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    pif.ml_valid     = 1'b0;
    pif.ml_class     = 3'd0;
    pif.ml_conf      = 8'h00;
    pif.cb_active_in = 1'b0;
    pif.host_clear   = 1'b0;
    rst_n            = 1'b0;
    idle(2);
    rst_n = 1'b1;

    chk("rst_mode",  32'(pif.cb_mode), 32'd0);
    chk("rst_param", 32'(pif.cb_param), 32'd0);
    chk("rst_load",  32'(pif.cb_load), 32'd0);
    chk("rst_state", 32'(pif.policy_state), 32'd0);
    chk("rst_trip",  32'(pif.trip_count), 32'd0);
    chk("rst_supp",  32'(pif.suppressed_count), 32'd0);

    // Persistence: three class-1 inferences five cycles apart.
    pif.cb_active_in = 1'b1;
    infer(3'd1, 8'h90);
    chk("p1_load",  32'(pif.cb_load), 32'd0);
    chk("p1_state", 32'(pif.policy_state), 32'd1);
    idle(4);
    infer(3'd1, 8'h90);
    chk("p2_load",  32'(pif.cb_load), 32'd0);
    idle(4);
    infer(3'd1, 8'h90);
    chk("p3_load",  32'(pif.cb_load), 32'd1);
    chk("p3_mode",  32'(pif.cb_mode), 32'd1);
    chk("p3_param", 32'(pif.cb_param), 32'h90);
    chk("p3_trip",  32'(pif.trip_count), 32'd1);
    chk("p3_state", 32'(pif.policy_state), 32'd2);
    tick();
    chk("p3_pulse", 32'(pif.cb_load), 32'd0);
    chk("p3_hold",  32'(pif.cb_mode), 32'd1);

    // Escalation and suppression while engaged.
    infer(3'd3, 8'h90);
    chk("esc_load",  32'(pif.cb_load), 32'd1);
    chk("esc_mode",  32'(pif.cb_mode), 32'd3);
    chk("esc_param", 32'(pif.cb_param), 32'h90);
    chk("esc_trip",  32'(pif.trip_count), 32'd2);
    pif.cb_active_in = 1'b0;
    infer(3'd2, 8'hA0);
    chk("sup_load",  32'(pif.cb_load), 32'd0);
    chk("sup_param", 32'(pif.cb_param), 32'h90);
    chk("sup_cnt",   32'(pif.suppressed_count), 32'(STATS));
    tick();
    chk("guard_hold", 32'(pif.policy_state), 32'd2);
    tick();
    chk("cool_enter", 32'(pif.policy_state), 32'd3);

    // Cooldown: lower classes suppressed, fast class-3 re-engages.
    for (int i = 0; i < 3; i++) begin
      infer(3'd2, 8'hA0);
      chk("cool_sup_load", 32'(pif.cb_load), 32'd0);
    end
    chk("cool_sup_state", 32'(pif.policy_state), 32'd3);
    chk("cool_sup_cnt",   32'(pif.suppressed_count), 32'(STATS * 4));
    infer(3'd3, 8'hF8);
    chk("cool_fast_load",  32'(pif.cb_load), 32'd1);
    chk("cool_fast_mode",  32'(pif.cb_mode), 32'd3);
    chk("cool_fast_param", 32'(pif.cb_param), 32'hF8);
    chk("cool_fast_state", 32'(pif.policy_state), 32'd2);
    chk("cool_fast_trip",  32'(pif.trip_count), 32'd3);

    // Full cooldown expiry back to IDLE.
    idle(2);
    chk("cd_guard", 32'(pif.policy_state), 32'd2);
    tick();
    chk("cd_enter", 32'(pif.policy_state), 32'd3);
    idle(255);
    chk("cd_last", 32'(pif.policy_state), 32'd3);
    tick();
    chk("cd_idle", 32'(pif.policy_state), 32'd0);
    chk("cd_mode_hold", 32'(pif.cb_mode), 32'd3);

    // Low confidence ignored; class change restarts arming; window expiry.
    infer(3'd1, 8'h7F);
    chk("lowconf_state", 32'(pif.policy_state), 32'd0);
    chk("lowconf_load",  32'(pif.cb_load), 32'd0);
    infer(3'd1, 8'h90);
    infer(3'd1, 8'h90);
    infer(3'd2, 8'h90);
    chk("switch_state", 32'(pif.policy_state), 32'd1);
    chk("switch_load",  32'(pif.cb_load), 32'd0);
    idle(63);
    chk("win_last", 32'(pif.policy_state), 32'd1);
    tick();
    chk("win_idle", 32'(pif.policy_state), 32'd0);

    // host_clear beats a simultaneous fast inference.
    infer(3'd2, 8'h90);
    chk("hc_arming", 32'(pif.policy_state), 32'd1);
    pif.host_clear = 1'b1;
    infer(3'd3, 8'hF0);
    pif.host_clear = 1'b0;
    chk("hc_load",  32'(pif.cb_load), 32'd1);
    chk("hc_mode",  32'(pif.cb_mode), 32'd0);
    chk("hc_param", 32'(pif.cb_param), 32'h00);
    chk("hc_state", 32'(pif.policy_state), 32'd0);
    chk("hc_trip",  32'(pif.trip_count), 32'd3);
    chk("hc_supp",  32'(pif.suppressed_count), 32'(STATS * 4));

    // Reset mid-ARMING.
    infer(3'd1, 8'h90);
    chk("rs_arming", 32'(pif.policy_state), 32'd1);
    pif.cb_active_in = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_state", 32'(pif.policy_state), 32'd0);
    chk("rs_trip",  32'(pif.trip_count), 32'd0);
    chk("rs_mode",  32'(pif.cb_mode), 32'd0);
    chk("rs_load",  32'(pif.cb_load), 32'd0);
    chk("rs_supp",  32'(pif.suppressed_count), 32'd0);

    // Fast inference from IDLE engages immediately.
    infer(3'd3, 8'hF0);
    chk("fast_load",  32'(pif.cb_load), 32'd1);
    chk("fast_mode",  32'(pif.cb_mode), 32'd3);
    chk("fast_param", 32'(pif.cb_param), 32'hF0);
    chk("fast_state", 32'(pif.policy_state), 32'd2);
    chk("fast_trip",  32'(pif.trip_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cb_policy_ctrl.md
Name: cb_policy_ctrl

Overview:
- Upstream policy stage that turns raw ML anomaly inferences into circuit-breaker commands for the order book matching engine.
- Drives the engine's cb_mode/cb_param/cb_load interface.
- Filters inferences by confidence, requires class persistence before engaging, and allows only severity escalation while a breaker is engaged.
- Enforces a cooldown after the engine self-heals, and watches the engine's cb_active to know when that happens.

Parameters:
- CONF_MIN, 128: minimum ml_conf for an inference to qualify.
- FAST_CONF, 224: ml_conf at or above which a class-3 inference engages with no persistence check.
- PERSIST, 3: consecutive same-class qualifying inferences needed to engage (1..15).
- ARM_WINDOW, 64: idle cycles allowed in ARMING before abandoning (1..1023).
- COOLDOWN, 256: cycles spent in COOLDOWN (1..1023).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, synchronous, active-low.
- ml_valid, input, 1: 1-cycle inference strobe.
- ml_class, input, 3: 0=NORMAL, 1=QUOTE_STUFFING, 2=ORDER_IMBALANCE, 3=FLASH_CRASH, 4-7=treated as NORMAL.
- ml_conf, input, 8: inference confidence.
- cb_active_in, input, 1: engine's cb_active.
- host_clear, input, 1: 1-cycle host release request.
- cb_mode, output, 2: mode to the engine.
- cb_param, output, 8: param to the engine.
- cb_load, output, 1: 1-cycle latch pulse to the engine.
- policy_state, output, 2: 0=IDLE, 1=ARMING, 2=ENGAGED, 3=COOLDOWN.
- trip_count, output, 8: count of nonzero-mode loads, saturating at 255.
- suppressed_count, output, 8: see Optional Feature.

Behaviour:
- Reset: all outputs 0 and state IDLE; persistence counter, candidate class, guard, timer and cooldown counter cleared. Reset mid-operation drops any pending load.
- Qualifying inference: ml_valid=1 and ml_class in {1,2,3} and ml_conf>=CONF_MIN.
- Class-to-mode map: 1->01, 2->10, 3->11. Severity equals the mode value.
- Fast inference: qualifying, ml_class=3 and ml_conf>=FAST_CONF.
- Issuing a load:
  - All outputs are registered; cb_load is high exactly one cycle, the cycle after the triggering input.
  - cb_mode/cb_param update in the same cycle as cb_load and then hold until the next load.
  - cb_param = ml_conf of the triggering inference.
  - A nonzero-mode load increments trip_count and sets a 2-cycle guard; cb_active_in is ignored while the guard is nonzero.
- IDLE:
  - Fast inference: load mode 11, go ENGAGED.
  - Other qualifying inference: candidate class := ml_class, count := 1. If PERSIST=1, load and go ENGAGED; otherwise go ARMING with the arm timer cleared.
  - All else: ignored.
- ARMING:
  - Arm timer counts cycles since the last ml_valid.
  - Fast inference: load 11, go ENGAGED.
  - Qualifying inference, same class: count+1. When the count reaches PERSIST, load and go ENGAGED.
  - Qualifying inference, different class: candidate := new class, count := 1, stay in ARMING.
  - ml_valid that does not qualify: go IDLE, count := 0.
  - Timer reaches ARM_WINDOW: go IDLE.
- ENGAGED (engaged severity = last loaded mode):
  - Qualifying inference with higher severity: load immediately (escalation), stay ENGAGED.
  - Qualifying inference with equal or lower severity: suppressed.
  - Guard is 0 and cb_active_in=0: go COOLDOWN with counter := COOLDOWN.
- COOLDOWN:
  - Counter decrements each cycle; at 0, go IDLE.
  - Fast inference: load 11, go ENGAGED.
  - Other qualifying inferences: suppressed.
- host_clear, in any state: load mode 00, param 00, trip_count unchanged, go IDLE.
  - host_clear beats a simultaneous ml_valid; that inference is dropped and not counted.
- Simultaneous cb_active_in fall and escalation in ENGAGED: escalation wins and the state stays ENGAGED.

Optional Feature:
- Macro: CB_POLICY_STATS_EN.
- Defined: suppressed_count increments, saturating at 255, for every qualifying inference suppressed in ENGAGED or COOLDOWN. Cleared only by reset.
- Undefined: suppressed_count is tied to 0 and no counter logic is built.

Test Plan:
- IDLE, three class-1 conf 0x90 inferences 5 cycles apart -> no load after the first two; cb_load one cycle after the third with cb_mode=01, cb_param=0x90, trip_count=1, policy_state=2.
- IDLE, single class-3 conf 0xF0 -> next cycle cb_load=1, cb_mode=11, cb_param=0xF0, state ENGAGED.
- Class-1 conf 0x7F -> no change. Then class-1, class-1, class-2 at conf 0x90 -> stays ARMING with candidate 2, no load. Then 64 idle cycles -> IDLE.
- Engaged at 01 with cb_active_in=1:
  - class-3 conf 0x90 -> escalation load 11/0x90, trip_count=2.
  - then class-2 conf 0xA0 -> no load; suppressed_count=1 with macro defined.
- ENGAGED, then cb_active_in=0 after the guard -> COOLDOWN:
  - class-2 conf 0xA0 x3 -> no load.
  - class-3 conf 0xF8 -> load 11/0xF8.
  - otherwise IDLE after 256 cycles.
- ARMING, host_clear and ml_valid class-3 conf 0xF0 in the same cycle -> cb_load with 00/0x00, state IDLE, trip_count unchanged. Then rst_n low for one cycle mid-ARMING -> all outputs 0, state IDLE.
